// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: run/pause/adjust FSM, 1 Hz and 2 Hz strobes, clear,
// and 4-digit display scan with blink-based blanking of the field being adjusted.
module stopwatch_ctrl #(
    parameter int DIV_1HZ   = 100000000,
    parameter int DIV_2HZ   = 50000000,
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause_btn,
    input  logic       clear_btn,
    input  logic       adj,
    input  logic       sel,
    output logic       cnt_en,
    output logic       inc_min,
    output logic       inc_sec,
    output logic       clear,
    output logic [1:0] digit_sel,
    output logic [3:0] an,
    output logic       blank,
    output logic [1:0] mode
);

    localparam int W1 = (DIV_1HZ   > 1) ? $clog2(DIV_1HZ)   : 1;
    localparam int W2 = (DIV_2HZ   > 1) ? $clog2(DIV_2HZ)   : 1;
    localparam int WS = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int WB = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_PAUSE = 2'd1;
    localparam logic [1:0] ST_ADJ   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          paused_q, paused_d;
    logic          pause_prev_q, clear_prev_q;
    logic [W1-1:0] p1_q, p1_d;
    logic [W2-1:0] p2_q, p2_d;
    logic [WS-1:0] sc_q, sc_d;
    logic [WB-1:0] bc_q, bc_d;
    logic          blink_q, blink_d;
    logic [1:0]    digit_q, digit_d;
    logic [3:0]    an_q, an_d;
    logic          cnt_en_q, cnt_en_d;
    logic          inc_min_q, inc_min_d;
    logic          inc_sec_q, inc_sec_d;
    logic          clear_q, clear_d;
    logic          blank_q, blank_d;
    logic          pause_edge, clear_edge, wrap1, wrap2, wrap_s, wrap_b;

    always_comb begin
        pause_edge = pause_btn & ~pause_prev_q;
        clear_edge = clear_btn & ~clear_prev_q;
        wrap1  = (p1_q == W1'(DIV_1HZ - 1));
        wrap2  = (p2_q == W2'(DIV_2HZ - 1));
        wrap_s = (sc_q == WS'(SCAN_DIV - 1));
        wrap_b = (bc_q == WB'(BLINK_DIV - 1));

        // Pause edges are ignored while adjusting; the flag remembers where to return.
        paused_d = paused_q;
        if (state_q != ST_ADJ && pause_edge)
            paused_d = ~paused_q;
        if (adj)
            state_d = ST_ADJ;
        else
            state_d = paused_d ? ST_PAUSE : ST_RUN;

        p1_d = p1_q;
        if (clear_edge)
            p1_d = '0;
        else if (state_q == ST_RUN)
            p1_d = wrap1 ? '0 : p1_q + 1'b1;

        // Held at zero outside ADJ, so every ADJ entry starts a fresh half-second.
        p2_d = '0;
        if (state_q == ST_ADJ)
            p2_d = wrap2 ? '0 : p2_q + 1'b1;

        cnt_en_d  = (state_q == ST_RUN) && wrap1 && !clear_edge;
        inc_min_d = (state_q == ST_ADJ) && wrap2 && !clear_edge && !sel;
        inc_sec_d = (state_q == ST_ADJ) && wrap2 && !clear_edge && sel;
        clear_d   = clear_edge;

        sc_d    = wrap_s ? '0 : sc_q + 1'b1;
        digit_d = wrap_s ? digit_q + 2'd1 : digit_q;
        bc_d    = wrap_b ? '0 : bc_q + 1'b1;
        blink_d = wrap_b ? ~blink_q : blink_q;
        an_d    = ~(4'b1000 >> digit_d);
        blank_d = (state_d == ST_ADJ) && !blink_d && (digit_d[1] == sel);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            paused_q     <= 1'b0;
            pause_prev_q <= 1'b0;
            clear_prev_q <= 1'b0;
            p1_q         <= '0;
            p2_q         <= '0;
            sc_q         <= '0;
            bc_q         <= '0;
            blink_q      <= 1'b0;
            digit_q      <= 2'd0;
            an_q         <= 4'b0111;
            cnt_en_q     <= 1'b0;
            inc_min_q    <= 1'b0;
            inc_sec_q    <= 1'b0;
            clear_q      <= 1'b0;
            blank_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            paused_q     <= paused_d;
            pause_prev_q <= pause_btn;
            clear_prev_q <= clear_btn;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            sc_q         <= sc_d;
            bc_q         <= bc_d;
            blink_q      <= blink_d;
            digit_q      <= digit_d;
            an_q         <= an_d;
            cnt_en_q     <= cnt_en_d;
            inc_min_q    <= inc_min_d;
            inc_sec_q    <= inc_sec_d;
            clear_q      <= clear_d;
            blank_q      <= blank_d;
        end
    end

    assign cnt_en    = cnt_en_q;
    assign inc_min   = inc_min_q;
    assign inc_sec   = inc_sec_q;
    assign clear     = clear_q;
    assign digit_sel = digit_q;
    assign an        = an_q;
    assign blank     = blank_q;
    assign mode      = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: cycle-level behavioural model plus directed and random stimulus.
module tb_stopwatch_ctrl;

    localparam int D1 = 10;
    localparam int D2 = 5;
    localparam int SC = 4;
    localparam int BL = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause_btn = 1'b0, clear_btn = 1'b0, adj = 1'b0, sel = 1'b0;
    logic       cnt_en, inc_min, inc_sec, clear, blank;
    logic [1:0] digit_sel, mode;
    logic [3:0] an;

    stopwatch_ctrl #(.DIV_1HZ(D1), .DIV_2HZ(D2), .SCAN_DIV(SC), .BLINK_DIV(BL)) dut (
        .clk(clk), .rst(rst), .pause_btn(pause_btn), .clear_btn(clear_btn),
        .adj(adj), .sel(sel), .cnt_en(cnt_en), .inc_min(inc_min), .inc_sec(inc_sec),
        .clear(clear), .digit_sel(digit_sel), .an(an), .blank(blank), .mode(mode)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: counts edges spent in RUN/ADJ and edges since reset.
    int m_mode = 0, m_run = 0, m_adjc = 0, m_n = 0;
    bit m_paused = 0, pp = 0, cp = 0;
    bit e_cnt = 0, e_min = 0, e_sec = 0, e_clr = 0, e_blank = 0;
    int e_digit = 0;
    logic [3:0] an_tbl [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = 0; m_paused = 0; m_run = 0; m_adjc = 0; m_n = 0; pp = 0; cp = 0;
            e_cnt = 0; e_min = 0; e_sec = 0; e_clr = 0; e_blank = 0; e_digit = 0;
        end else begin
            bit pe, ce, blink;
            pe = pause_btn && !pp;
            ce = clear_btn && !cp;
            e_cnt = (m_mode == 0) && (m_run % D1 == D1 - 1) && !ce;
            e_min = (m_mode == 2) && (m_adjc % D2 == D2 - 1) && !ce && !sel;
            e_sec = (m_mode == 2) && (m_adjc % D2 == D2 - 1) && !ce && sel;
            e_clr = ce;
            m_run  = ce ? 0 : m_run + ((m_mode == 0) ? 1 : 0);
            m_adjc = (m_mode == 2) ? m_adjc + 1 : 0;
            if (m_mode != 2 && pe) m_paused = !m_paused;
            m_mode = adj ? 2 : (m_paused ? 1 : 0);
            m_n++;
            e_digit = (m_n / SC) % 4;
            blink   = ((m_n / BL) % 2) == 1;
            e_blank = (m_mode == 2) && !blink && ((e_digit / 2) == int'(sel));
            pp = pause_btn;
            cp = clear_btn;
        end
    end

    int cyc = 0, last_cnt = -1, gap = 0;
    int n_cnt = 0, n_min = 0, n_sec = 0, n_clr = 0;

    always @(negedge clk) begin
        cyc++;
        chk("cnt_en",    cnt_en,    e_cnt);
        chk("inc_min",   inc_min,   e_min);
        chk("inc_sec",   inc_sec,   e_sec);
        chk("clear",     clear,     e_clr);
        chk("digit_sel", digit_sel, e_digit);
        chk("an",        an,        an_tbl[e_digit]);
        chk("blank",     blank,     e_blank);
        chk("mode",      mode,      m_mode);
        if (cnt_en) begin
            if (last_cnt >= 0) gap = cyc - last_cnt;
            last_cnt = cyc;
            n_cnt++;
        end
        if (inc_min) n_min++;
        if (inc_sec) n_sec++;
        if (clear)   n_clr++;
    end

    // Waits (bounded) until a new cnt_en is seen; returns negedges elapsed.
    task automatic wait_cnt(input string nm, output int k);
        int s;
        s = n_cnt;
        k = 0;
        while (n_cnt == s && k < 40) begin
            @(negedge clk); #1;
            k++;
            pause_btn = 1'b0;
        end
        if (n_cnt == s) chk({nm, "_timeout"}, k, -1);
    endtask

    initial begin
        int s_cnt, s_min, s_sec, s_clr, k, changes, bad;
        logic [3:0] prev;

        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk("rst_outs", {cnt_en, inc_min, inc_sec, clear, blank, digit_sel, an, mode},
                {5'b0, 2'd0, 4'b0111, 2'd0});
        @(negedge clk);
        rst = 1'b1;
        #1 s_cnt = n_cnt;

        // Free run from reset
        repeat (35) @(negedge clk);
        #1;
        chk("run_cnt3", n_cnt - s_cnt, 3);
        chk("run_gap", gap, 10);
        chk("run_mode", mode, 0);

        // Pause then resume
        pause_btn = 1'b1;
        @(negedge clk); pause_btn = 1'b0;
        #1 s_cnt = n_cnt;
        repeat (19) @(negedge clk);
        #1;
        chk("pause_mode", mode, 1);
        chk("pause_nocnt", n_cnt - s_cnt, 0);
        pause_btn = 1'b1;
        wait_cnt("resume", k);
        chk("resume_lat", k, 5);

        // Adjust minutes then seconds
        adj = 1'b1; sel = 1'b0;
        s_cnt = n_cnt; s_min = n_min; s_sec = n_sec;
        repeat (12) @(negedge clk);
        sel = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("adj_min2", n_min - s_min, 2);
        chk("adj_sec2", n_sec - s_sec, 2);
        chk("adj_nocnt", n_cnt - s_cnt, 0);
        chk("adj_mode", mode, 2);

        // Return from adjust to RUN / PAUSE
        adj = 1'b0;
        @(negedge clk); #1 chk("adj_ret_run", mode, 0);
        pause_btn = 1'b1;
        @(negedge clk); pause_btn = 1'b0;
        #1 chk("paused_again", mode, 1);
        adj = 1'b1;
        @(negedge clk); pause_btn = 1'b1;
        @(negedge clk); pause_btn = 1'b0;
        @(negedge clk); adj = 1'b0;
        @(negedge clk); #1 chk("adj_ret_pause", mode, 1);
        pause_btn = 1'b1;
        @(negedge clk); pause_btn = 1'b0;
        #1 chk("unpause", mode, 0);

        // Clear coinciding with the 1 Hz wrap
        wait_cnt("pre_clear", k);
        repeat (9) @(negedge clk);
        clear_btn = 1'b1;
        s_clr = n_clr;
        @(negedge clk); #1;
        chk("clr_pulse", clear, 1);
        chk("clr_supp", cnt_en, 0);
        clear_btn = 1'b0;
        wait_cnt("post_clear", k);
        chk("clr_next", k, 10);
        chk("clr_once", n_clr - s_clr, 1);

        // Anode scan rotation
        prev = an; changes = 0; bad = 0;
        repeat (32) begin
            @(negedge clk); #1;
            if (an != prev) begin
                changes++;
                if (an != {prev[0], prev[3:1]}) bad++;
            end
            prev = an;
        end
        chk("scan_changes", changes, 8);
        chk("scan_order", bad, 0);

        // Randomized traffic with occasional asynchronous reset
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            pause_btn = ($urandom_range(0, 7) == 0);
            clear_btn = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 39) == 0) adj = ~adj;
            if ($urandom_range(0, 9) == 0)  sel = ~sel;
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b0;
                #1 chk("async_rst", {cnt_en, inc_min, inc_sec, clear, blank, an, mode},
                        {5'b0, 4'b0111, 2'd0});
                @(negedge clk);
                rst = 1'b1;
            end
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
